// File: rtl/key_debouncer.sv
// Push-button conditioner: 2-FF synchroniser plus per-channel debounce FSM with press/release pulses.
// Optional auto-repeat of key_press while held is enabled by defining KEY_AUTOREPEAT_EN.
module key_debouncer #(
    parameter int N_KEYS        = 2,
    parameter int STABLE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [N_KEYS-1:0] IDLE_RAW = ACTIVE_LOW ? '1 : '0;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] pressed;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= IDLE_RAW;
            sync2 <= IDLE_RAW;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    assign pressed = ACTIVE_LOW ? ~sync2 : sync2;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        state_t           state, state_nxt;
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic             level_q, press_q, release_q;
        logic             level_nxt, press_nxt, release_nxt;

`ifdef KEY_AUTOREPEAT_EN
        localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RW   = $clog2(RMAX + 1);
        localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
        localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
        logic [RW-1:0] rcnt, rcnt_nxt;
        logic          rphase, rphase_nxt;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                state     <= RELEASED;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
                rcnt      <= '0;
                rphase    <= 1'b0;
`endif
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
`ifdef KEY_AUTOREPEAT_EN
                rcnt      <= rcnt_nxt;
                rphase    <= rphase_nxt;
`endif
            end
        end

        // cnt holds the samples of the new level already seen; acceptance on the STABLE_CYCLES-th one
        always_comb begin
            state_nxt   = state;
            cnt_nxt     = '0;
            level_nxt   = level_q;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_nxt    = '0;
            rphase_nxt  = 1'b0;
`endif
            case (state)
                RELEASED: begin
                    if (pressed[i]) begin
                        if (STABLE_CYCLES == 1) begin
                            state_nxt = PRESSED;
                            level_nxt = 1'b1;
                            press_nxt = 1'b1;
                        end else begin
                            state_nxt = PRESS_WAIT;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed[i]) begin
                        state_nxt = RELEASED;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = PRESSED;
                        level_nxt = 1'b1;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!pressed[i]) begin
                        if (STABLE_CYCLES == 1) begin
                            state_nxt   = RELEASED;
                            level_nxt   = 1'b0;
                            release_nxt = 1'b1;
                        end else begin
                            state_nxt = RELEASE_WAIT;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end else begin
`ifdef KEY_AUTOREPEAT_EN
                        // first repeat after REPEAT_DELAY cycles, then one every REPEAT_PERIOD
                        if (rcnt == (rphase ? PER_LAST : DLY_LAST)) begin
                            press_nxt  = 1'b1;
                            rphase_nxt = 1'b1;
                        end else begin
                            rcnt_nxt   = rcnt + 1'b1;
                            rphase_nxt = rphase;
                        end
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed[i]) begin
                        state_nxt = PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt   = RELEASED;
                        level_nxt   = 1'b0;
                        release_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = RELEASED;
                end
            endcase
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
    end

endmodule
